// File: rtl/tt_sel_ctrl.sv
// tt_sel_ctrl: pad-driven select counter plus one-hot power-gate / enable sequencing for a G_X*G_Y module grid.
// Build option: define TT_SEL_PG_EN for power sequencing (OFF/PWR_UP/ON/PWR_DN); undefined keeps power always on.

module tt_sel_lane #(
  parameter int unsigned ID = 0,
  parameter int unsigned AW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_nxt,
  input  logic          pg_nxt,
  input  logic          ena_nxt,
  output logic          pg,
  output logic          ena
);
  logic hit;
  assign hit = (addr_nxt == AW'(ID));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg  <= 1'b0;
      ena <= 1'b0;
    end else begin
      pg  <= pg_nxt & hit;
      ena <= ena_nxt & hit;
    end
  end
endmodule

module tt_sel_ctrl #(
  parameter int unsigned G_X    = 4,
  parameter int unsigned G_Y    = 2,
  parameter int unsigned PG_DLY = 4,
  localparam int unsigned N_UM  = G_X * G_Y,
  localparam int unsigned AW    = (N_UM > 1) ? $clog2(N_UM) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sel_rst_n_in,
  input  logic            sel_inc_in,
  input  logic            ena_in,
  output logic [AW-1:0]   sel_addr,
  output logic [N_UM-1:0] um_pg_vdd,
  output logic [N_UM-1:0] um_ena,
  output logic            busy
);
`ifdef TT_SEL_PG_EN
  localparam bit PG_EN = 1'b1;
`else
  localparam bit PG_EN = 1'b0;
`endif

  if (PG_DLY < 1 || PG_DLY > 255) begin : g_bad_pg_dly
    $error("tt_sel_ctrl: PG_DLY must be 1..255");
  end

  logic [1:0] rst_sync, ena_sync;
  logic [2:0] inc_sync;
  logic       sel_clr_n, inc_edge, leave;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
      ena_sync <= '0;
      inc_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], sel_rst_n_in};
      ena_sync <= {ena_sync[0], ena_in};
      inc_sync <= {inc_sync[1:0], sel_inc_in};
    end
  end

  assign sel_clr_n = rst_sync[1];
  assign inc_edge  = inc_sync[1] & ~inc_sync[2];
  assign leave     = inc_edge | ~sel_clr_n;

  // Clear has priority over an increment arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sel_addr <= '0;
    else if (!sel_clr_n) sel_addr <= '0;
    else if (inc_edge)   sel_addr <= (sel_addr == AW'(N_UM - 1)) ? '0 : sel_addr + 1'b1;
  end

  typedef enum logic [1:0] {S_OFF, S_PWR_UP, S_ON, S_PWR_DN} state_t;
  state_t        state, state_nxt;
  logic [AW-1:0] pwr_addr, addr_nxt;

`ifdef TT_SEL_PG_EN
  localparam logic [7:0] CNT_LAST = 8'(PG_DLY - 1);
  logic [7:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    addr_nxt  = pwr_addr;
    cnt_nxt   = cnt;
    case (state)
      S_OFF: if (sel_clr_n) begin
        state_nxt = S_PWR_UP;
        addr_nxt  = sel_addr;
        cnt_nxt   = '0;
      end
      S_PWR_UP: begin
        if (leave)                 state_nxt = S_PWR_DN;
        else if (cnt == CNT_LAST)  state_nxt = S_ON;
        else                       cnt_nxt   = cnt + 8'd1;
      end
      S_ON:    if (leave) state_nxt = S_PWR_DN;
      default: state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OFF;
      pwr_addr <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pwr_addr <= addr_nxt;
      cnt      <= cnt_nxt;
      busy     <= (state_nxt == S_PWR_UP) || (state_nxt == S_PWR_DN);
    end
  end
`else
  always_comb begin
    state_nxt = state;
    addr_nxt  = pwr_addr;
    case (state)
      S_OFF: if (sel_clr_n) begin
        state_nxt = S_ON;
        addr_nxt  = sel_addr;
      end
      S_ON:    if (leave) state_nxt = S_OFF;
      default: state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OFF;
      pwr_addr <= '0;
    end else begin
      state    <= state_nxt;
      pwr_addr <= addr_nxt;
    end
  end

  assign busy = 1'b0;
`endif

  // Lanes register their outputs from next-state so they line up with the state register.
  logic            pg_nxt, ena_nxt;
  logic [N_UM-1:0] lane_pg;
  assign pg_nxt  = (state_nxt != S_OFF);
  assign ena_nxt = (state_nxt == S_ON) & ena_sync[1];

  for (genvar i = 0; i < int'(N_UM); i++) begin : g_lane
    tt_sel_lane #(.ID(i), .AW(AW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr_nxt (addr_nxt),
      .pg_nxt   (pg_nxt),
      .ena_nxt  (ena_nxt),
      .pg       (lane_pg[i]),
      .ena      (um_ena[i])
    );
  end

  assign um_pg_vdd = PG_EN ? lane_pg : '1;
endmodule

// File: tb/tb_tt_sel_ctrl.sv
// Randomized bench for tt_sel_ctrl against a phase-level reference model; works with or without TT_SEL_PG_EN.
`timescale 1ns/1ps
module tb_tt_sel_ctrl;
  localparam int G_X = 4, G_Y = 2, PG_DLY = 4, N = G_X * G_Y, AW = 3;
`ifdef TT_SEL_PG_EN
  localparam bit           PG     = 1'b1;
  localparam logic [N-1:0] PG_OFF = '0;
`else
  localparam bit           PG     = 1'b0;
  localparam logic [N-1:0] PG_OFF = '1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, sel_rst_n_in = 1'b0, sel_inc_in = 1'b0, ena_in = 1'b0;
  logic [AW-1:0] sel_addr;
  logic [N-1:0]  um_pg_vdd, um_ena;
  logic          busy;

  tt_sel_ctrl #(.G_X(G_X), .G_Y(G_Y), .PG_DLY(PG_DLY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel_rst_n_in (sel_rst_n_in),
    .sel_inc_in   (sel_inc_in),
    .ena_in       (ena_in),
    .sel_addr     (sel_addr),
    .um_pg_vdd    (um_pg_vdd),
    .um_ena       (um_ena),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pad histories (index 0 = newest sampled edge), phase, remaining power-up cycles.
  typedef enum int {M_OFF, M_UP, M_ON, M_DN} mph_t;
  mph_t ph;
  int   left, addr, paddr;
  bit   rh[3], ih[3], eh[3];

  function automatic void m_reset();
    ph = M_OFF; left = 0; addr = 0; paddr = 0;
    for (int i = 0; i < 3; i++) begin rh[i] = 0; ih[i] = 0; eh[i] = 0; end
  endfunction

  task automatic m_step();
    bit clr_n, inc, leave;
    int old_addr;
    clr_n    = rh[1];
    inc      = ih[1] && !ih[2];
    leave    = inc || !clr_n;
    old_addr = addr;
    if (!clr_n)   addr = 0;
    else if (inc) addr = (addr + 1) % N;
    case (ph)
      M_OFF: if (clr_n) begin
        paddr = old_addr;
        if (PG) begin ph = M_UP; left = PG_DLY; end
        else ph = M_ON;
      end
      M_UP: begin
        if (leave)          ph = M_DN;
        else if (left == 1) ph = M_ON;
        else                left--;
      end
      M_ON: if (leave) begin
        if (PG) ph = M_DN;
        else    ph = M_OFF;
      end
      default: ph = M_OFF;
    endcase
    rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = sel_rst_n_in;
    ih[2] = ih[1]; ih[1] = ih[0]; ih[0] = sel_inc_in;
    eh[2] = eh[1]; eh[1] = eh[0]; eh[0] = ena_in;
  endtask

  task automatic compare();
    logic [N-1:0] oh, exp_pg, exp_ena;
    oh = '0;
    oh[paddr] = 1'b1;
`ifdef TT_SEL_PG_EN
    exp_pg = (ph != M_OFF) ? oh : '0;
`else
    exp_pg = '1;
`endif
    exp_ena = (ph == M_ON && eh[2]) ? oh : '0;
    chk("sel_addr", sel_addr, addr);
    chk("um_pg_vdd", um_pg_vdd, exp_pg);
    chk("um_ena", um_ena, exp_ena);
    chk("busy", busy, (ph == M_UP || ph == M_DN));
    chk("ena_onehot", $countones(um_ena) <= 1, 1);
    chk("ena_without_pg", um_ena & ~um_pg_vdd, 0);
`ifdef TT_SEL_PG_EN
    chk("pg_onehot", $countones(um_pg_vdd) <= 1, 1);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_step();
    else       m_reset();
    @(negedge clk);
    compare();
  endtask

  task automatic pulse();
    sel_inc_in = 1'b1;
    repeat (2) tick();
    sel_inc_in = 1'b0;
    repeat (8) tick();
  endtask

  // Reset lands between clock edges; outputs must drop before the next edge.
  task automatic async_rst();
    @(posedge clk);
    m_step();
    #2;
    chk("pre_rst_busy", busy, PG);
    chk("pre_rst_pg", um_pg_vdd, PG ? 8'h01 : 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("async_pg", um_pg_vdd, PG_OFF);
    chk("async_busy", busy, 0);
    chk("async_ena", um_ena, 0);
    chk("async_addr", sel_addr, 0);
    m_reset();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int nb;
    m_reset();
    repeat (3) tick();
    chk("rst_addr", sel_addr, 0);
    chk("rst_pg", um_pg_vdd, PG_OFF);
    chk("rst_ena", um_ena, 0);
    chk("rst_busy", busy, 0);

    rst_n = 1'b1; sel_rst_n_in = 1'b1; ena_in = 1'b1;
    nb = 0;
    repeat (12) begin tick(); nb += int'(busy); end
    chk("pwrup_cycles", nb, PG ? PG_DLY : 0);
    chk("ena_after_pwrup", um_ena, 8'h01);

    repeat (3) pulse();
    repeat (10) tick();
    chk("addr_3", sel_addr, 3);
    chk("ena_addr_3", um_ena, 8'h08);
    chk("pg_addr_3", um_pg_vdd, PG ? 8'h08 : 8'hFF);

    repeat (5) pulse();
    repeat (10) tick();
    chk("wrap_addr", sel_addr, 0);
    chk("wrap_ena", um_ena, 8'h01);

    repeat (5) pulse();
    repeat (10) tick();
    chk("ena_addr_5", um_ena, 8'h20);
    sel_rst_n_in = 1'b0;
    nb = 0;
    repeat (6) begin tick(); nb += int'(busy); end
    chk("clr_dn_cycles", nb, PG ? 1 : 0);
    chk("clr_addr", sel_addr, 0);
    chk("clr_pg", um_pg_vdd, PG_OFF);
    chk("clr_ena", um_ena, 0);

    sel_rst_n_in = 1'b1;
    for (int i = 0; i < 600; i++) begin
      int p;
      p = (i < 300) ? 4 : 20;
      if ($urandom_range(0, p - 1) == 0)     sel_inc_in = ~sel_inc_in;
      if ($urandom_range(0, 2 * p - 1) == 0) ena_in     = ~ena_in;
      sel_rst_n_in = ($urandom_range(0, 4 * p - 1) != 0);
      tick();
    end

    rst_n = 1'b0; sel_rst_n_in = 1'b1; sel_inc_in = 1'b0; ena_in = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    async_rst();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("reup_ena", um_ena, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
